segway_mtr_drv: RTL and testbench

- Downstream stage of the balance/steer math block. Consumes the saturated signed wheel speeds `lft_spd` and `rght_spd`.
- Produces complementary, non-overlapping H-bridge PWM pairs for the left and right motors.
- One free-running 11-bit PWM counter is shared by both channels. Duty is latched once per period. Each channel has its own dead-time (non-overlap) generator.

---
 rtl/segway_mtr_drv.sv | 149 ++++++++++++++
 tb/tb_segway_mtr_drv.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/segway_mtr_drv.sv
// segway_mtr_drv: shared 11-bit PWM counter feeding two dead-time protected
// H-bridge drive pairs. Over-current shutdown is built only with `OVR_I_SHTDWN_EN.
module segway_mtr_drv #(
  parameter int unsigned NONOVERLAP = 32
`ifdef OVR_I_SHTDWN_EN
  ,
  parameter int unsigned BLANK = 255
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
`ifdef OVR_I_SHTDWN_EN
  input  logic        OVR_I_lft,
  input  logic        OVR_I_rght,
  output logic        ovr_i_shtdwn,
`endif
  output logic        PWM1_lft,
  output logic        PWM2_lft,
  output logic        PWM1_rght,
  output logic        PWM2_rght,
  output logic        cycle_start
);

  localparam int unsigned CNT_W = 11;
  localparam int unsigned DT_W  = 8;
  localparam int unsigned N_CH  = 2;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] DUTY_RST  = CNT_W'(1024);
  localparam logic [DT_W-1:0]  DT_LAST   = DT_W'(NONOVERLAP - 1);

  logic [CNT_W-1:0]            cnt;
  logic [N_CH-1:0][CNT_W-1:0]  duty_map;
  logic [N_CH-1:0][CNT_W-1:0]  duty_q;
  logic [N_CH-1:0]             raw_q;
  logic [N_CH-1:0]             raw_prev;
  logic [N_CH-1:0][DT_W-1:0]   dt_cnt;
  logic [N_CH-1:0]             pwm1_q;
  logic [N_CH-1:0]             pwm2_q;
  logic                        force_off_c;
  logic                        spd_lsb_unused;

  // Offset-binary duty: (spd + 2048) >> 1, the LSB of speed is dropped
  assign duty_map[0] = {~lft_spd[11],  lft_spd[10:1]};
  assign duty_map[1] = {~rght_spd[11], rght_spd[10:1]};
  assign spd_lsb_unused = lft_spd[0] ^ rght_spd[0];

  // Free-running period counter, wraps 2047 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Gated by rst_n so the decode reads 0 while reset holds cnt at 0
  assign cycle_start = rst_n & (cnt == '0);

  // Duty sampled on the last count so it takes effect exactly at cnt==0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= {N_CH{DUTY_RST}};
    end else if (cnt == CNT_MAX) begin
      duty_q <= duty_map;
    end
  end

  // Raw PWM compare and one-cycle history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q    <= '0;
      raw_prev <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        raw_q[i] <= (cnt < duty_q[i]);
      end
      raw_prev <= raw_q;
    end
  end

  // Non-overlap: any raw edge blanks both sides until raw is stable NONOVERLAP clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_cnt <= '0;
      pwm1_q <= '0;
      pwm2_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (force_off_c || (raw_q[i] != raw_prev[i])) begin
          dt_cnt[i] <= '0;
          pwm1_q[i] <= 1'b0;
          pwm2_q[i] <= 1'b0;
        end else if (dt_cnt[i] == DT_LAST) begin
          pwm1_q[i] <= raw_q[i];
          pwm2_q[i] <= ~raw_q[i];
        end else begin
          dt_cnt[i] <= dt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign PWM1_lft  = pwm1_q[0];
  assign PWM2_lft  = pwm2_q[0];
  assign PWM1_rght = pwm1_q[1];
  assign PWM2_rght = pwm2_q[1];

`ifdef OVR_I_SHTDWN_EN
  logic       flag_q;
  logic [1:0] oc_cnt;
  logic       ovr_sample_c;
  logic       period_flag_c;
  logic       shtdwn_set_c;

  assign ovr_sample_c  = (OVR_I_lft | OVR_I_rght) && (cnt >= CNT_W'(BLANK));
  assign period_flag_c = flag_q | ovr_sample_c;
  assign shtdwn_set_c  = (oc_cnt == 2'd3);
  // Kill the drive in the same clock the sticky flag is registered
  assign force_off_c   = ovr_i_shtdwn | shtdwn_set_c;

  // Per-period flag, consecutive flagged-period counter and sticky shutdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q       <= 1'b0;
      oc_cnt       <= '0;
      ovr_i_shtdwn <= 1'b0;
    end else begin
      if (cnt == CNT_MAX) begin
        flag_q <= 1'b0;
        if (!period_flag_c) begin
          oc_cnt <= '0;
        end else if (oc_cnt != 2'd3) begin
          oc_cnt <= oc_cnt + 1'b1;
        end
      end else if (ovr_sample_c) begin
        flag_q <= 1'b1;
      end
      if (shtdwn_set_c) begin
        ovr_i_shtdwn <= 1'b1;
      end
    end
  end
`else
  assign force_off_c = 1'b0;
`endif

endmodule

// File: tb/tb_segway_mtr_drv.sv
// Directed bench for segway_mtr_drv: period high-time counts, duty latching,
// async reset, and (with OVR_I_SHTDWN_EN) the over-current shutdown.
module tb_segway_mtr_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght;
  logic        cycle_start;
`ifdef OVR_I_SHTDWN_EN
  logic        OVR_I_lft;
  logic        OVR_I_rght;
  logic        ovr_i_shtdwn;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int h1l, h2l, h1r, h2r, ovl, cs;

  always #5 clk = ~clk;

  segway_mtr_drv dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lft_spd     (lft_spd),
    .rght_spd    (rght_spd),
`ifdef OVR_I_SHTDWN_EN
    .OVR_I_lft   (OVR_I_lft),
    .OVR_I_rght  (OVR_I_rght),
    .ovr_i_shtdwn(ovr_i_shtdwn),
`endif
    .PWM1_lft    (PWM1_lft),
    .PWM2_lft    (PWM2_lft),
    .PWM1_rght   (PWM1_rght),
    .PWM2_rght   (PWM2_rght),
    .cycle_start (cycle_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    h1l = 0; h2l = 0; h1r = 0; h2r = 0; ovl = 0; cs = 0;
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge
  task automatic adv(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      h1l += int'(PWM1_lft);
      h2l += int'(PWM2_lft);
      h1r += int'(PWM1_rght);
      h2r += int'(PWM2_rght);
      cs  += int'(cycle_start);
      if ((PWM1_lft && PWM2_lft) || (PWM1_rght && PWM2_rght)) ovl++;
    end
  endtask

  // Reset pulse, released on a falling edge; cyc 0 is the cnt==0 cycle
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    #1;
    clr();
  endtask

`ifdef OVR_I_SHTDWN_EN
  // One-clock OVR_I_lft pulse while cnt == v in period p
  task automatic pulse(input int p, input int v);
    adv(p * 2048 + v - cyc);
    OVR_I_lft = 1'b1;
    adv(1);
    OVR_I_lft = 1'b0;
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    lft_spd  = 12'h000;
    rght_spd = 12'h000;
`ifdef OVR_I_SHTDWN_EN
    OVR_I_lft  = 1'b0;
    OVR_I_rght = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm1_lft", PWM1_lft, 0);
    check("rst_pwm2_lft", PWM2_lft, 0);
    check("rst_pwm1_rght", PWM1_rght, 0);
    check("rst_pwm2_rght", PWM2_rght, 0);
    check("rst_cycle_start", cycle_start, 0);

    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    #1;
    clr();
    check("cycle_start_at_cnt0", cycle_start, 1);
    adv(33);
    check("post_rst_deadtime_highs", h1l + h2l + h1r + h2r, 0);
    adv(1);
    check("post_rst_pwm1_lft_on", PWM1_lft, 1);
    check("post_rst_pwm1_rght_on", PWM1_rght, 1);

    // Full period at spd=0: 992 high / 992 low-side / 64 dead
    clr();
    adv(2048);
    check("spd0_pwm1_lft", h1l, 992);
    check("spd0_pwm2_lft", h2l, 992);
    check("spd0_pwm1_rght", h1r, 992);
    check("spd0_pwm2_rght", h2r, 992);
    check("spd0_cycle_start", cs, 1);
    check("spd0_overlap", ovl, 0);

    // Max forward left; right change mid-period must not affect this period
    lft_spd = 12'h7FF;
    adv(2047);
    clr();
    adv(67);
    rght_spd = 12'h400;
    adv(1981);
    check("max_pwm1_lft", h1l, 2015);
    check("max_pwm2_lft", h2l, 0);
    check("midchg_pwm1_rght", h1r, 992);
    check("midchg_pwm2_rght", h2r, 992);
    check("max_overlap", ovl, 0);

    // Right now at duty 0x600; left switches to full reverse next period
    lft_spd = 12'h800;
    clr();
    adv(2048);
    check("newduty_pwm1_rght", h1r, 1504);
    check("newduty_pwm2_rght", h2r, 480);
    check("max2_pwm1_lft", h1l, 2015);
    check("rev_first_low_side", h2l, 1);

    clr();
    adv(2048);
    check("rev_pwm1_lft", h1l, 0);
    check("rev_pwm2_lft", h2l, 2048);
    check("newduty2_pwm1_rght", h1r, 1504);
    check("newduty2_pwm2_rght", h2r, 480);
    check("newduty_cycle_start", cs, 1);
    check("newduty_overlap", ovl, 0);

    // Asynchronous reset at cnt=500 with PWM1_rght high
    adv(467);
    check("pre_rst_pwm1_rght", PWM1_rght, 1);
    check("pre_rst_pwm2_lft", PWM2_lft, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm1_rght", PWM1_rght, 0);
    check("async_rst_pwm2_lft", PWM2_lft, 0);
    check("async_rst_cycle_start", cycle_start, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    #1;
    clr();
    check("rerst_cycle_start", cycle_start, 1);
    adv(33);
    check("rerst_deadtime_highs", h1l + h2l + h1r + h2r, 0);
    adv(1);
    check("rerst_pwm1_rght_on", PWM1_rght, 1);
    check("rerst_duty_reset_lft", PWM1_lft, 1);

`ifdef OVR_I_SHTDWN_EN
    // Three consecutive flagged periods -> shutdown
    lft_spd = 12'h000;
    rght_spd = 12'h000;
    do_reset();
    pulse(0, 300);
    pulse(1, 300);
    pulse(2, 300);
    adv(3 * 2048 - cyc);
    check("oc_not_yet", ovr_i_shtdwn, 0);
    adv(1);
    check("oc_shtdwn_set", ovr_i_shtdwn, 1);
    check("oc_pwm2_lft_forced", PWM2_lft, 0);
    check("oc_pwm2_rght_forced", PWM2_rght, 0);
    clr();
    adv(2100);
    check("oc_all_off", h1l + h2l + h1r + h2r, 0);
    check("oc_sticky", ovr_i_shtdwn, 1);

    // Pulses inside the blanking window are ignored
    do_reset();
    pulse(0, 100);
    pulse(1, 100);
    pulse(2, 100);
    adv(3 * 2048 + 10 - cyc);
    check("blank_no_shtdwn", ovr_i_shtdwn, 0);

    // A clean period clears the consecutive count
    do_reset();
    pulse(0, 300);
    pulse(1, 300);
    pulse(3, 300);
    pulse(4, 300);
    clr();
    adv(5 * 2048 + 10 - cyc);
    check("gap_no_shtdwn", ovr_i_shtdwn, 0);
    check("gap_pwm_alive", (h1l > 0) ? 1 : 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
